// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver.
// State encoding and protocol byte constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, run-length glitch filter and
// falling-edge strobe for one raw PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic          meta;
    logic          sync;
    logic          filt;
    logic [CW-1:0] run;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            filt <= 1'b1;
            fall <= 1'b0;
            run  <= '0;
        end else begin
            meta <= line;
            sync <= meta;
            fall <= 1'b0;
            if (sync == filt) begin
                run <= '0;
            end else if (run == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN consecutive samples disagree: accept new level
                filt <= sync;
                fall <= filt;
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: framing checks, timeout and
// folding of E0/F0 prefixes into per-event flags.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       extended,
    output logic       released,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state;
    logic          fall;
    logic          data_m;
    logic          data_s;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic          acc_valid;
    logic          ext_pend;
    logic          rel_pend;
    logic [TW-1:0] tcnt;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk  (clk),
        .reset(reset),
        .line (ps2_clk),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_m <= 1'b1;
            data_s <= 1'b1;
        end else begin
            data_m <= ps2_data;
            data_s <= data_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            acc_valid  <= 1'b0;
            ext_pend   <= 1'b0;
            rel_pend   <= 1'b0;
            tcnt       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            extended   <= 1'b0;
            released   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            acc_valid  <= 1'b0;

            // shreg holds the accepted byte while the FSM idles
            if (acc_valid) begin
                if (shreg == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    rel_pend <= 1'b1;
                end else begin
                    code       <= shreg;
                    extended   <= ext_pend;
                    released   <= rel_pend;
                    code_valid <= 1'b1;
                    ext_pend   <= 1'b0;
                    rel_pend   <= 1'b0;
                end
            end

            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fall && !data_s) begin
                        state   <= DATA;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par   <= data_s;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!data_s || !(^{shreg, par})) begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            rel_pend  <= 1'b0;
                        end else begin
                            acc_valid <= 1'b1;
                        end
                    end
                end
            endcase

            if (state != IDLE && !fall &&
                tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                rel_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed plus randomized frames against a byte-level model
// of prefix folding and error handling.
module tb_ps2_scan_receiver;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       extended;
    logic       released;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int         err_seen = 0;
    int         err_exp = 0;
    int         overlap = 0;
    bit         m_ext = 0;
    bit         m_rel = 0;
    logic [7:0] last_code = 8'h00;

    ps2_scan_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .code_valid(code_valid),
        .extended  (extended),
        .released  (released),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid) got_q.push_back({code, extended, released});
            if (frame_err) err_seen++;
            if (code_valid && frame_err) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pbit(input logic d);
        @(negedge clk) ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par,
                         input bit bad_stop);
        pbit(1'b0);
        for (int i = 0; i < 8; i++) pbit(b[i]);
        pbit((~^b) ^ bad_par);
        pbit(~bad_stop);
        @(negedge clk) ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Byte-level reference: what a correct receiver reports
    task automatic model(input logic [7:0] b, input bit err);
        if (err) begin
            m_ext = 0;
            m_rel = 0;
            err_exp++;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            exp_q.push_back({b, m_ext, m_rel});
            last_code = b;
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic settle(input string tag);
        logic [9:0] g;
        logic [9:0] e;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_errs"}, err_seen, err_exp);
        chk({tag, "_nev"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_ev"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_hold"}, code, last_code);
        chk({tag, "_ovl"}, overlap, 0);
    endtask

    task automatic send(input logic [7:0] b, input bit bp, input bit bs,
                        input string tag);
        frame(b, bp, bs);
        model(b, bp | bs);
        settle(tag);
    endtask

    initial begin
        logic [7:0] rb;
        int         r;
        int         k;
        int         n;
        int         e0;
        bit         seen;

        repeat (4) @(negedge clk);
        chk("rst_code", code, 0);
        chk("rst_cv", code_valid, 0);
        chk("rst_ext", extended, 0);
        chk("rst_rel", released, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'h1C, 0, 0, "make");
        send(8'hF0, 0, 0, "brk_pre");
        send(8'h1C, 0, 0, "brk");
        send(8'hE0, 0, 0, "ext_pre");
        send(8'hF0, 0, 0, "ext_brk_pre");
        send(8'h75, 0, 0, "up_rel");
        send(8'h75, 0, 0, "up_make");

        send(8'hE0, 0, 0, "e0_before_err");
        send(8'h1C, 1, 0, "bad_par");
        send(8'h1C, 0, 1, "bad_stop");
        send(8'h1C, 0, 0, "after_err");

        // ps2_clk glitch one sample short of the filter length
        seen = 0;
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        ps2_data = 1'b1;
        chk("glitch_busy", seen, 0);
        settle("glitch");

        // Partial frame, then silence until timeout
        e0 = err_seen;
        pbit(1'b0);
        pbit(1'b1);
        pbit(1'b0);
        pbit(1'b1);
        @(negedge clk) ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        chk("to_busy_mid", busy, 1);
        n = 0;
        while (err_seen == e0 && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_fired", err_seen, e0 + 1);
        model(8'h00, 1);
        repeat (5) @(negedge clk);
        settle("timeout");
        send(8'h1C, 0, 0, "after_to");

        // Reset mid-frame with a pending E0
        send(8'hE0, 0, 0, "pre_rst_e0");
        pbit(1'b0);
        for (int i = 0; i < 5; i++) pbit(1'b1);
        @(negedge clk) reset = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_code", code, 0);
        reset = 1'b0;
        m_ext = 0;
        m_rel = 0;
        last_code = 8'h00;
        repeat (2 * HALF) @(negedge clk);
        send(8'h29, 0, 0, "post_rst");

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 9);
            rb = 8'($urandom);
            if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h1C;
            if (r < 2) rb = 8'hE0;
            else if (r < 4) rb = 8'hF0;
            k = $urandom_range(0, 7);
            send(rb, k == 0, k == 1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
